cache_color_filler: RTL and testbench

Feeder for the three-channel sliding-window colour cache. On `start` it fetches 16-bit halfwords from data memory for three channel rows and writes them into the cache's six 16-bit entries. It then issues shift pulses so the cache presents `n_win` consecutive 24-bit (3-byte) windows per channel, one per shift. It refills the cache's low entries every second shift and hands each settled window to the consumer with a valid/ready handshake.

---
 rtl/cache_fill_pkg.sv | 30 +++
 rtl/cache_fill_mem_if.sv | 59 +++++
 rtl/cache_color_filler.sv | 170 +++++++++++++++++
 tb/tb_cache_color_filler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the three-channel colour-cache filler.
package cache_fill_pkg;

    localparam int CF_NCH = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETTLE,
        ST_PRESENT,
        ST_SHIFT,
        ST_DONE
    } fill_state_t;

    // Each cache write walks request -> write -> gap before the next request.
    typedef enum logic [1:0] {
        PH_REQ,
        PH_WRITE,
        PH_GAP
    } fill_phase_t;

    function automatic logic [2:0] even_entry(input logic [1:0] ch);
        return {ch, 1'b0};
    endfunction

    function automatic logic [2:0] odd_entry(input logic [1:0] ch);
        return {ch, 1'b1};
    endfunction

endpackage

// File: rtl/cache_fill_mem_if.sv
// Memory read port of the filler: request/valid handshake, halfword register and
// the optional wait-cycle counter built only when CACHE_FILL_PERF_EN is defined.
module cache_fill_mem_if
    import cache_fill_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_en,
    input  logic [AW-1:0] req_addr,
    input  logic          clr_perf,
    input  logic          mem_valid,
    input  logic [31:0]   mem_rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   hw,
    output logic [15:0]   perf_stall
);

    logic [15:0] hw_q;
    logic        unused_hi;

    // Request is combinational from the FSM so it drops the moment reset hits.
    assign mem_req   = req_en;
    assign mem_addr  = req_en ? req_addr : '0;
    assign hw        = hw_q;
    assign unused_hi = ^mem_rdata[31:16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hw_q <= '0;
        end else if (req_en && mem_valid) begin
            hw_q <= mem_rdata[15:0];
        end
    end

`ifdef CACHE_FILL_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (clr_perf) begin
            stall_q <= '0;
        end else if (req_en && !mem_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign perf_stall = stall_q;
`else
    logic unused_clr;

    assign unused_clr = clr_perf;
    assign perf_stall = '0;
`endif

endmodule

// File: rtl/cache_color_filler.sv
// Feeds the three-channel sliding-window colour cache and presents its windows;
// the stall counter in cache_fill_mem_if exists only with CACHE_FILL_PERF_EN.
module cache_color_filler
    import cache_fill_pkg::*;
#(
    parameter int AW = 32,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr [0:2],
    input  logic [NW-1:0] n_win,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_valid,
    input  logic [31:0]   mem_rdata,
    output logic          cache_we,
    output logic [2:0]    cache_addr,
    output logic [32:0]   cache_di,
    output logic          cache_sh,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [15:0]   perf_stall
);

    fill_state_t   state, state_nxt;
    fill_phase_t   phase, phase_nxt;
    logic [AW-1:0] ptr [CF_NCH];
    logic [NW-1:0] n_lat;
    logic [NW-1:0] win_cnt;
    logic [NW-1:0] win_nxt;
    logic [NW-1:0] sh_cnt;
    logic [1:0]    ch;
    logic          odd;
    logic          refill;
    logic          accept;
    logic          req_en;
    logic          we;
    logic [15:0]   hw;
    logic          unused_bits;

    assign win_nxt     = win_cnt + NW'(1);
    assign unused_bits = base_addr[0][0] ^ base_addr[1][0] ^ base_addr[2][0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            phase <= PH_REQ;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        accept    = 1'b0;
        req_en    = 1'b0;
        we        = 1'b0;
        cache_sh  = 1'b0;
        win_valid = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done      = (state == ST_DONE);
                state_nxt = ST_IDLE;
                phase_nxt = PH_REQ;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (n_win != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                case (phase)
                    PH_REQ: begin
                        req_en = 1'b1;
                        if (mem_valid) phase_nxt = PH_WRITE;
                    end
                    PH_WRITE: begin
                        we        = 1'b1;
                        phase_nxt = PH_GAP;
                    end
                    default: begin
                        // ch steps past the last channel once the burst's final write lands
                        phase_nxt = PH_REQ;
                        if (ch == 2'(CF_NCH)) state_nxt = ST_SETTLE;
                    end
                endcase
            end
            ST_SETTLE: state_nxt = ST_PRESENT;
            ST_PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) state_nxt = (win_nxt == n_lat) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                cache_sh  = 1'b1;
                phase_nxt = PH_REQ;
                state_nxt = sh_cnt[0] ? ST_FILL : ST_SETTLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CF_NCH; c++) ptr[c] <= '0;
            n_lat   <= '0;
            win_cnt <= '0;
            sh_cnt  <= '0;
            ch      <= '0;
            odd     <= 1'b0;
            refill  <= 1'b0;
        end else if (accept) begin
            for (int c = 0; c < CF_NCH; c++) ptr[c] <= {base_addr[c][AW-1:1], 1'b0};
            n_lat   <= n_win;
            win_cnt <= '0;
            sh_cnt  <= '0;
            ch      <= '0;
            odd     <= 1'b0;
            refill  <= 1'b0;
        end else begin
            // Every write consumes ptr[ch]; the initial load alternates even/odd
            // entries, a refill only touches the odd ones.
            if (state == ST_FILL && phase == PH_WRITE) begin
                ptr[ch] <= ptr[ch] + AW'(2);
                if (odd) begin
                    ch  <= ch + 2'd1;
                    odd <= refill;
                end else begin
                    odd <= 1'b1;
                end
            end
            if (state == ST_PRESENT && win_ready) win_cnt <= win_nxt;
            if (state == ST_SHIFT) begin
                sh_cnt <= sh_cnt + NW'(1);
                if (sh_cnt[0]) begin
                    ch     <= '0;
                    odd    <= 1'b1;
                    refill <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign cache_we   = we;
    assign cache_addr = we ? (odd ? odd_entry(ch) : even_entry(ch)) : '0;
    assign cache_di   = we ? {17'd0, hw} : '0;

    cache_fill_mem_if #(
        .AW(AW)
    ) u_mem_if (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en),
        .req_addr  (ptr[ch]),
        .clr_perf  (accept),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .hw        (hw),
        .perf_stall(perf_stall)
    );

endmodule

// File: tb/tb_cache_color_filler.sv
// Bench for cache_color_filler: memory model with programmable latency, a model of
// the colour cache, and scoreboards for cache events and presented windows.
module tb_cache_color_filler;

`ifdef CACHE_FILL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr [0:2];
    logic [15:0] n_win = '0;
    logic        busy, done, mem_req, mem_valid;
    logic [31:0] mem_addr, mem_rdata;
    logic        cache_we, cache_sh, win_valid;
    logic        win_ready = 1'b1;
    logic [2:0]  cache_addr;
    logic [32:0] cache_di;
    logic [15:0] perf_stall;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int wait_cnt = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int req_cycles = 0;
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr = '0;

    logic [71:0] exp_q[$];
    logic [36:0] exp_ev_q[$];

    logic [15:0] ent [0:7];
    logic [23:0] win_q [0:2];
    logic [71:0] cache_win;

    cache_color_filler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .n_win     (n_win),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .cache_we  (cache_we),
        .cache_addr(cache_addr),
        .cache_di  (cache_di),
        .cache_sh  (cache_sh),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .perf_stall(perf_stall)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    // ---------------- environment models
    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] h;
        logic [15:0] t;
        h = {a[31:1], 1'b0};
        case (h)
            32'h0000_0100: return 16'h1122;
            32'h0000_0102: return 16'h3344;
            32'h0000_0104: return 16'h5566;
            default: begin
                t = h[16:1] * 16'h9E37;
                return t ^ h[31:16];
            end
        endcase
    endfunction

    function automatic logic [7:0] row_byte(input logic [31:0] base, input int j);
        logic [15:0] hw;
        hw = mem_hw({base[31:1], 1'b0} + 32'(2 * (j / 2)));
        return (j % 2 == 0) ? hw[15:8] : hw[7:0];
    endfunction

    function automatic logic [23:0] row_win(input logic [31:0] base, input int k);
        return {row_byte(base, k), row_byte(base, k + 1), row_byte(base, k + 2)};
    endfunction

    assign mem_valid = mem_req && (wait_cnt >= mem_lat);
    assign mem_rdata = {16'hDEAD, mem_hw(mem_addr)};

    always @(posedge clk) begin
        if (mem_req && !mem_valid) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Cache model: entries update at the edge ending T, window outputs one edge later.
    always @(posedge clk) begin
        if (cache_we) ent[cache_addr] <= cache_di[15:0];
        if (cache_sh) begin
            for (int c = 0; c < 3; c++) begin
                ent[2*c]   <= {ent[2*c][7:0], ent[2*c+1][15:8]};
                ent[2*c+1] <= {ent[2*c+1][7:0], 8'h00};
            end
        end
        for (int c = 0; c < 3; c++) win_q[c] <= {ent[2*c], ent[2*c+1][15:8]};
    end

    assign cache_win = {win_q[0], win_q[1], win_q[2]};

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: win_ready = 1'b1;
            1: win_ready = 1'($urandom_range(0, 1));
            default: win_ready = 1'b0;
        endcase
    end

    // ---------------- checking
    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [36:0] obs;
        if (rst) begin
            if (done) done_cnt++;
            if (mem_req) req_cycles++;
            if (mem_req && prev_req && !prev_valid && (mem_addr != prev_addr))
                check("addr_stable", 72'(mem_addr), 72'(prev_addr));
            prev_req   = mem_req;
            prev_valid = mem_valid;
            prev_addr  = mem_addr;
            if (cache_we && cache_sh) check("we_sh_excl", 72'(cache_sh), 72'(0));
            if (cache_we || cache_sh) begin
                obs = cache_sh ? {1'b1, 36'd0} : {1'b0, cache_addr, cache_di};
                if (exp_ev_q.size() == 0) check("ev_unexpected", 72'(exp_ev_q.size()), 72'(1));
                else check("cache_event", 72'(obs), 72'(exp_ev_q.pop_front()));
            end
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) check("win_unexpected", 72'(exp_q.size()), 72'(1));
                else check("window", cache_win, exp_q.pop_front());
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    // ---------------- drivers
    task automatic push_expect(input logic [31:0] b0, b1, b2, input int nw);
        logic [31:0] b [3];
        b[0] = {b0[31:1], 1'b0};
        b[1] = {b1[31:1], 1'b0};
        b[2] = {b2[31:1], 1'b0};
        if (nw > 0) begin
            for (int c = 0; c < 3; c++)
                for (int e = 0; e < 2; e++)
                    exp_ev_q.push_back({1'b0, 3'(2*c + e), 17'd0, mem_hw(b[c] + 32'(2*e))});
        end
        for (int k = 0; k < nw; k++)
            exp_q.push_back({row_win(b[0], k), row_win(b[1], k), row_win(b[2], k)});
        for (int s = 1; s < nw; s++) begin
            exp_ev_q.push_back({1'b1, 36'd0});
            if (s % 2 == 0) begin
                for (int c = 0; c < 3; c++)
                    exp_ev_q.push_back({1'b0, 3'(2*c + 1), 17'd0, mem_hw(b[c] + 32'(2 + s))});
            end
        end
    endtask

    task automatic drive_start(input logic [31:0] b0, b1, b2, input int nw);
        @(posedge clk);
        #1;
        start        = 1'b1;
        base_addr[0] = b0;
        base_addr[1] = b1;
        base_addr[2] = b2;
        n_win        = 16'(nw);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] b0, b1, b2, input int nw, input int lat,
                           input int hold, input int poke, input bit measure);
        int n;
        int d0;
        int r0;
        int reads;
        logic [71:0] w0;
        mem_lat = lat;
        push_expect(b0, b1, b2, nw);
        if (hold > 0) ready_mode = 2;
        d0 = done_cnt;
        r0 = req_cycles;
        drive_start(b0, b1, b2, nw);
        @(negedge clk);
        if (nw == 0) begin
            check("zero_done", 72'(done), 72'(1));
            check("zero_busy", 72'(busy), 72'(0));
        end else begin
            check("busy_rise", 72'(busy), 72'(1));
        end
        if (measure) begin
            n = 1;
            while (!win_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("first_valid_cycle", 72'(n), 72'(20));
        end
        if (hold > 0) begin
            n = 0;
            while (!win_valid && n < 400) begin
                @(negedge clk);
                n++;
            end
            w0 = cache_win;
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", 72'(win_valid), 72'(1));
                check("bp_sh_we", 72'({cache_sh, cache_we}), 72'(0));
                check("bp_window", cache_win, w0);
            end
            ready_mode = 0;
        end
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
            if (poke > 0 && n == poke) begin
                start        = 1'b1;
                base_addr[0] = 32'h0000_9000;
                base_addr[1] = 32'h0000_A000;
                base_addr[2] = 32'h0000_B000;
                n_win        = 16'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_once", 72'(done_cnt - d0), 72'(1));
        check("busy_end", 72'(busy), 72'(0));
        check("win_left", 72'(exp_q.size()), 72'(0));
        check("event_left", 72'(exp_ev_q.size()), 72'(0));
        reads = (nw > 0) ? 6 + 3 * ((nw - 1) / 2) : 0;
        check("perf_stall", 72'(perf_stall), PERF_ON ? 72'(reads * lat) : 72'(0));
        if (nw == 0) check("zero_no_req", 72'(req_cycles - r0), 72'(0));
        exp_q.delete();
        exp_ev_q.delete();
    endtask

    // ---------------- sequence
    initial begin
        int n;
        int d0;
        base_addr[0] = '0;
        base_addr[1] = '0;
        base_addr[2] = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 72'({busy, done, mem_req, cache_we, cache_sh, win_valid}), 72'(0));
        check("rst_data", 72'({mem_addr, cache_addr, cache_di}), 72'(0));
        check("rst_perf", 72'(perf_stall), 72'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_job(32'h100, 32'h200, 32'h300, 3, 0, 0, 0, 1'b1);
        run_job(32'h100, 32'h200, 32'h300, 3, 3, 0, 0, 1'b0);
        run_job(32'h100, 32'h200, 32'h300, 3, 0, 0, 0, 1'b0);
        run_job(32'h100, 32'h200, 32'h300, 3, 0, 10, 0, 1'b0);
        run_job(32'h100, 32'h200, 32'h300, 0, 0, 0, 0, 1'b0);
        run_job(32'h400, 32'h500, 32'h601, 4, 1, 0, 5, 1'b0);
        run_job(32'h1000, 32'h2000, 32'h3000, 1, 0, 0, 0, 1'b0);
        run_job(32'h1000, 32'h2000, 32'h3000, 2, 2, 0, 0, 1'b0);
        run_job(32'hFFFF_FFFA, 32'h7FFF_FFFE, 32'h0000_0010, 7, 1, 0, 0, 1'b0);

        // Abort in the middle of the entry-3 read, then a clean job from scratch.
        mem_lat = 2;
        push_expect(32'h100, 32'h200, 32'h300, 3);
        drive_start(32'h100, 32'h200, 32'h300, 3);
        n = 0;
        while (!(mem_req && mem_addr == 32'h202) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_entry3", 72'({mem_req, mem_addr}), 72'({1'b1, 32'h202}));
        d0  = done_cnt;
        rst = 1'b0;
        #1;
        check("abort_ctrl", 72'({busy, done, mem_req, cache_we, cache_sh, win_valid}), 72'(0));
        check("abort_data", 72'({mem_addr, cache_addr, cache_di}), 72'(0));
        check("abort_perf", 72'(perf_stall), 72'(0));
        exp_q.delete();
        exp_ev_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 72'(done_cnt - d0), 72'(0));
        run_job(32'h100, 32'h200, 32'h300, 3, 0, 0, 0, 1'b1);

        ready_mode = 1;
        for (int j = 0; j < 4; j++)
            run_job($urandom(), $urandom(), $urandom(), $urandom_range(1, 9),
                    $urandom_range(0, 2), 0, 0, 1'b0);
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
